clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// MM:SS clock with a run mode and two set modes. All outputs come from registered state.
// A shared prescaler drives the one-second tick in RUN and the blink strobe in the set modes.
module clock_set_ctrl #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic       clk,
  input  logic       clr_,
  input  logic       mode,
  input  logic       inc,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [1:0] state,
  output logic       tick,
  output logic       blink
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StSetMin = 2'd1,
    StSetSec = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          blink_q, blink_d;
  logic [3:0]    sec_ones_q, sec_ones_d, min_ones_q, min_ones_d;
  logic [2:0]    sec_tens_q, sec_tens_d, min_tens_q, min_tens_d;
  logic          wrap;

  // Increments a tens/ones pair modulo 60, result packed as {tens, ones}.
  function automatic logic [6:0] bcd_inc(input logic [2:0] tens, input logic [3:0] ones);
    if (ones == 4'd9) begin
      if (tens == 3'd5) return 7'd0;
      return {tens + 3'd1, 4'd0};
    end
    return {tens, ones + 4'd1};
  endfunction

  assign wrap = (presc_q == PrescMax);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    blink_d    = blink_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;

    if (mode) begin
      // A mode pulse wins over inc; the new mode starts with a fresh prescaler and blink phase.
      case (state_q)
        StRun:    state_d = StSetMin;
        StSetMin: state_d = StSetSec;
        default:  state_d = StRun;
      endcase
      presc_d = '0;
      blink_d = 1'b0;
    end else begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
      case (state_q)
        StRun: begin
          if (wrap) begin
            {sec_tens_d, sec_ones_d} = bcd_inc(sec_tens_q, sec_ones_q);
            if (sec_tens_q == 3'd5 && sec_ones_q == 4'd9) begin
              {min_tens_d, min_ones_d} = bcd_inc(min_tens_q, min_ones_q);
            end
          end
        end
        StSetMin: begin
          if (wrap) blink_d = ~blink_q;
          if (inc) {min_tens_d, min_ones_d} = bcd_inc(min_tens_q, min_ones_q);
        end
        StSetSec: begin
          if (wrap) blink_d = ~blink_q;
          if (inc) {sec_tens_d, sec_ones_d} = bcd_inc(sec_tens_q, sec_ones_q);
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_) begin
      state_q    <= StRun;
      presc_q    <= '0;
      blink_q    <= 1'b0;
      sec_ones_q <= '0;
      sec_tens_q <= '0;
      min_ones_q <= '0;
      min_tens_q <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      blink_q    <= blink_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign state    = state_q;
  assign tick     = (state_q == StRun) && wrap;
  assign blink    = blink_q;

endmodule
